// File: rtl/melody_pkg.sv
// Shared definitions for the melody sequencer: controller states, score-word
// field layout and the end-of-score marker.
package melody_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_PLAY  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Score word layout: {rest, dur[3:0], tune[3:0]}
    localparam int REST_BIT = 8;
    localparam int DUR_HI   = 7;
    localparam int DUR_LO   = 4;
    localparam int TUNE_HI  = 3;
    localparam int TUNE_LO  = 0;

    // A zero duration marks the end of the score
    localparam logic [3:0] END_DUR = 4'd0;

    function automatic logic is_end_marker(input logic [8:0] word);
        return (word[DUR_HI:DUR_LO] == END_DUR);
    endfunction

endpackage

// File: rtl/beat_timer.sv
// Loadable down-counter timing one note. Flags the final cycle, the gap
// window at the end of the note, and the cycle just before the gap opens so
// the registered gate can fall exactly when the gap begins.
module beat_timer #(
    parameter int CNT_W      = 27,
    parameter int GAP_CYCLES = 600_000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_last,
    output logic             o_in_gap,
    output logic             o_gap_next
);

    localparam logic [CNT_W-1:0] ONE_V = CNT_W'(1);
    localparam logic [CNT_W-1:0] GAP_V = CNT_W'(GAP_CYCLES);

    logic [CNT_W-1:0] r_remaining;

    // Remaining-cycle counter: load on note start, count down to zero and rest there
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_remaining <= '0;
        end else if (i_load) begin
            r_remaining <= i_load_val;
        end else if (r_remaining != '0) begin
            r_remaining <= r_remaining - ONE_V;
        end else begin
            r_remaining <= r_remaining;
        end
    end

    assign o_last     = (r_remaining == ONE_V);
    assign o_in_gap   = (r_remaining <= GAP_V);
    assign o_gap_next = (r_remaining == (GAP_V + ONE_V));

endmodule

// File: rtl/melody_sequencer.sv
// Score-playback controller: fetches score words from a synchronous ROM,
// drives tune code and note gate for dur beats with an articulation gap,
// handles rests, end marker and optional looping.
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int BEAT_CYCLES = 6_000_000,
    parameter int GAP_CYCLES  = 600_000,
    parameter int ADDR_W      = 8
) (
    input  logic              clk12M,
    input  logic              Rst,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic [8:0]        rom_data,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [3:0]        tune,
    output logic              note_on,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(15 * BEAT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  BEAT_V   = CNT_W'(BEAT_CYCLES);
    localparam logic [CNT_W-1:0]  GAP_V    = CNT_W'(GAP_CYCLES);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t            r_state;
    logic              r_rom_en;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [3:0]        r_tune;
    logic              r_note_on;
    logic              r_busy;
    logic              r_done;
    logic              r_rest;

    logic [3:0]        w_dur;
    logic              w_rest;
    logic [3:0]        w_tune;
    logic              w_is_end;
    logic [CNT_W-1:0]  w_load_val;
    logic              w_load;
    logic              w_last;
    logic              w_in_gap;
    logic              w_gap_next;

    assign w_dur      = rom_data[DUR_HI:DUR_LO];
    assign w_rest     = rom_data[REST_BIT];
    assign w_tune     = rom_data[TUNE_HI:TUNE_LO];
    assign w_is_end   = is_end_marker(rom_data);
    assign w_load_val = CNT_W'(w_dur) * BEAT_V;
    assign w_load     = (r_state == ST_LOAD) && !w_is_end;

    beat_timer #(
        .CNT_W      (CNT_W),
        .GAP_CYCLES (GAP_CYCLES)
    ) u_beat_timer (
        .i_clk      (clk12M),
        .i_rst      (Rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_last     (w_last),
        .o_in_gap   (w_in_gap),
        .o_gap_next (w_gap_next)
    );

    // Playback FSM with all outputs registered; stop overrides every state
    always_ff @(posedge clk12M) begin
        if (Rst) begin
            r_state    <= ST_IDLE;
            r_rom_en   <= 1'b0;
            r_rom_addr <= '0;
            r_tune     <= 4'd0;
            r_note_on  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rest     <= 1'b0;
        end else if (stop) begin
            r_state    <= ST_IDLE;
            r_rom_en   <= 1'b0;
            r_note_on  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state    <= ST_FETCH;
                        r_rom_addr <= '0;
                        r_rom_en   <= 1'b1;
                        r_busy     <= 1'b1;
                    end else begin
                        r_state <= r_state;
                    end
                end
                ST_FETCH: begin
                    r_rom_en <= 1'b0;
                    r_state  <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (w_is_end) begin
                        if (loop) begin
                            r_rom_addr <= '0;
                            r_rom_en   <= 1'b1;
                            r_state    <= ST_FETCH;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        if (!w_rest) begin
                            r_tune <= w_tune;
                        end else begin
                            r_tune <= r_tune;
                        end
                        r_rest    <= w_rest;
                        r_note_on <= !w_rest && (w_load_val > GAP_V);
                        r_state   <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (w_last) begin
                        r_rom_addr <= r_rom_addr + ADDR_ONE;
                        r_rom_en   <= 1'b1;
                        r_note_on  <= 1'b0;
                        r_state    <= ST_FETCH;
                    end else begin
                        // Gate falls on the cycle the remaining count reaches the gap
                        r_note_on <= !r_rest && !w_in_gap && !w_gap_next;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_rom_en  <= 1'b0;
                    r_note_on <= 1'b0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

    assign rom_en   = r_rom_en;
    assign rom_addr = r_rom_addr;
    assign tune     = r_tune;
    assign note_on  = r_note_on;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Score-playback controller for the tune-driven square-wave generator. It fetches score words from a synchronous ROM, drives the 4-bit tune code and a note gate for the configured number of beats, and inserts an articulation gap so repeated notes stay distinct. It handles rests, end-of-score detection and optional looping. It sits between the score ROM and the wave generator, and everything it does is derived from the 12 MHz system clock.

## Interface
- BEAT_CYCLES, 6_000_000: clk12M cycles per beat (0.5 s at 12 MHz); must be ≥ 2.
- GAP_CYCLES, 600_000: gate-low cycles at the end of each sounded note; must be < BEAT_CYCLES.
- ADDR_W, 8: score ROM address width.
- clk12M  in  1  system clock, 12 MHz.
- Rst  in  1  reset, synchronous, active-high.
- start  in  1  level-sampled; begins playback at address 0 when idle.
- stop  in  1  aborts playback; has priority over start.
- loop  in  1  sampled at end marker: 1 restarts at address 0, 0 finishes.
- rom_data  in  9  score word {rest, dur[3:0], tune[3:0]}, valid the cycle after rom_en.
- rom_en  out  1  ROM read enable.
- rom_addr  out  ADDR_W  ROM address.
- tune  out  4  tune code to the wave generator (0=low G … 8+=high C).
- note_on  out  1  gate; high while a note sounds.
- busy  out  1  high in any state except IDLE and DONE.
- done  out  1  one-cycle pulse on reaching the end marker with loop=0.

## Operation
- States: IDLE, FETCH, LOAD, PLAY, DONE.
- IDLE: if start=1 and stop=0, go to FETCH with rom_addr=0.
- FETCH: rom_en=1 for one cycle, then go to LOAD.
- LOAD: decode rom_data.
  - dur==0 is the end marker. With loop=1, set rom_addr=0 and go to FETCH. With loop=0, go to DONE and pulse done.
  - Otherwise latch tune (only if rest=0), load the note counter with dur×BEAT_CYCLES, latch rest, and go to PLAY.
- PLAY: note_on = ~rest AND (remaining > GAP_CYCLES). On the last cycle, rom_addr increments and the state goes to FETCH.
- DONE: outputs idle. start (with stop=0) goes to FETCH at address 0.
- rom_addr wraps from 2^ADDR_W−1 to 0; no end marker is needed.
- stop=1 in any state: go to IDLE next cycle, note_on=0, rom_en=0. tune holds.
- start while busy is ignored. loop is sampled only in LOAD.
- A rest leaves tune unchanged and keeps note_on=0 for the full duration.
- Note counter width: ceil(log2(15×BEAT_CYCLES+1)) bits. The multiplication is performed at that width.

## Timing
- Reset values: rom_en=0, rom_addr=0, tune=0, note_on=0, busy=0, done=0, state=IDLE. All outputs are registered.
- start sampled high in cycle n: FETCH in n+1 (rom_en=1, rom_addr=0), LOAD in n+2, PLAY in n+3. tune and note_on are valid from n+3.
- Sounded note: note_on high for dur×BEAT_CYCLES−GAP_CYCLES cycles, then low for GAP_CYCLES cycles.
- Inter-note overhead: 2 cycles (FETCH and LOAD), with note_on=0.
- done is high for exactly the cycle in which the state is DONE-entry. busy drops in that same cycle.
- Rst mid-note: all outputs return to their reset values on the next edge.

## Structure
- Package melody_pkg holds:
  - the state enum;
  - the score-word field positions (REST_BIT=8, DUR=7:4, TUNE=3:0);
  - END_DUR=0.
- Sub-module beat_timer: loadable down-counter for note length. It outputs last (remaining==1) and in_gap (remaining ≤ GAP_CYCLES).

## Test plan
Use BEAT_CYCLES=10 and GAP_CYCLES=2 throughout.
- Reset → all outputs 0. Hold Rst for 3 cycles during PLAY → note_on=0, tune=0, state IDLE.
- ROM {0,2,5},{0,0,0}; start in cycle 0:
  - rom_addr=0 in cycle 1;
  - note_on=1 and tune=5 in cycles 3–20;
  - note_on=0 in cycles 21–22;
  - rom_addr=1 in cycle 23;
  - done pulse in cycle 25, busy=0 from cycle 25.
- ROM {0,1,3},{1,1,0},{0,1,4},{0,0,0} → sequence is tune=3 note for 8 cycles, 2-cycle gap, 2-cycle fetch, 10-cycle rest with tune still 3, then tune=4.
- Same ROM with loop=1 → after the end marker rom_addr returns to 0, no done pulse, tune=3 replays.
- stop pulsed during PLAY → next cycle note_on=0, busy=0, tune held. start and stop in the same cycle while idle → stays IDLE.
- ADDR_W=2, four non-marker notes → rom_addr sequence is 0,1,2,3,0 with no done pulse.
